// File: rtl/noc_port_arbiter_if.sv
// noc_port_arbiter_if
//   Request/response bundle between N requesters, the arbiter and one output link.
//   req_valid/req_data/req_ready : per-requester packet handshake (slice i at [i*WIDTH +: WIDTH])
//   out_valid/out_data/out_ready : output-register handshake towards the link
//   out_src                      : index of the requester whose packet is held
//   pkt_count                    : saturating count of packets accepted downstream
//   master modport: requesters + downstream side; slave modport: the arbiter.
interface noc_port_arbiter_if #(
    parameter int WIDTH = 11,
    parameter int N     = 5,
    parameter int CNT_W = 16
);
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic [SRC_W-1:0]   out_src;
    logic [CNT_W-1:0]   pkt_count;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, pkt_count
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, pkt_count
    );
endinterface

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter
//   Round-robin arbiter feeding a one-entry output register for a node output link.
//   i_clk  : clock, all state on rising edge
//   i_rst  : synchronous active-high reset
//   io_bus : noc_port_arbiter_if.slave (requests in, grants/held packet/count out)
//   At most one grant per cycle; the pointer moves to one past the winner on each
//   transfer, so every valid requester is served within N grants.
module noc_port_arbiter #(
    parameter int WIDTH = 11,
    parameter int N     = 5,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    noc_port_arbiter_if.slave    io_bus
);
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SRC_W-1:0]   r_src;
    logic [SRC_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_can_accept;
    logic               w_found;
    logic               w_grant;
    logic               w_out_hs;
    logic [SRC_W-1:0]   w_win;
    logic [SRC_W-1:0]   w_ptr_nxt;
    logic [N-1:0]       w_req_ready;
    logic [WIDTH-1:0]   w_win_data;

    // (base + off) mod N for off in 0..N-1
    function automatic logic [SRC_W-1:0] f_wrap(input logic [SRC_W-1:0] base, input int off);
        logic [SRC_W:0] s;
        s = {1'b0, base} + (SRC_W+1)'(off);
        if (s >= (SRC_W+1)'(N)) s = s - (SRC_W+1)'(N);
        return s[SRC_W-1:0];
    endfunction

    assign w_can_accept = (r_state == S_EMPTY) || io_bus.out_ready;
    assign w_out_hs     = (r_state == S_FULL) && io_bus.out_ready;

    // Scan from the far end back to ptr so the closest valid requester wins last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (io_bus.req_valid[f_wrap(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_grant = w_found && w_can_accept && !i_rst;

    always_comb begin
        w_req_ready = '0;
        for (int i = 0; i < N; i++)
            w_req_ready[i] = w_grant && (w_win == SRC_W'(i));
    end

    assign w_win_data = io_bus.req_data[w_win*WIDTH +: WIDTH];
    assign w_ptr_nxt  = (w_win == SRC_W'(N-1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_out_hs && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_EMPTY: begin
                    if (w_grant) begin
                        r_state <= S_FULL;
                        r_data  <= w_win_data;
                        r_src   <= w_win;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                S_FULL: begin
                    // Drain and refill in one edge when a grant coincides with out_ready.
                    if (w_grant) begin
                        r_data <= w_win_data;
                        r_src  <= w_win;
                        r_ptr  <= w_ptr_nxt;
                    end else if (io_bus.out_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign io_bus.req_ready = w_req_ready;
    assign io_bus.out_valid = (r_state == S_FULL);
    assign io_bus.out_data  = r_data;
    assign io_bus.out_src   = r_src;
    assign io_bus.pkt_count = r_cnt;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter
//   Directed stimulus against two arbiters sharing inputs (CNT_W=16 and CNT_W=4).
//   A queue-free reference model of the output register, pointer and counter is
//   checked every cycle, plus literal expectations at key points of each scenario.
module tb_noc_port_arbiter;
    localparam int WIDTH = 11;
    localparam int N     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_port_arbiter_if #(.WIDTH(WIDTH), .N(N), .CNT_W(16)) if0 ();
    noc_port_arbiter_if #(.WIDTH(WIDTH), .N(N), .CNT_W(4))  if1 ();

    assign if1.req_valid = if0.req_valid;
    assign if1.req_data  = if0.req_data;
    assign if1.out_ready = if0.out_ready;

    noc_port_arbiter #(.WIDTH(WIDTH), .N(N), .CNT_W(16)) dut0 (.i_clk(clk), .i_rst(rst), .io_bus(if0.slave));
    noc_port_arbiter #(.WIDTH(WIDTH), .N(N), .CNT_W(4))  dut1 (.i_clk(clk), .i_rst(rst), .io_bus(if1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] data [N];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v, input logic ordy);
        @(posedge clk);
        #1;
        rst = r;
        if0.req_valid = v;
        if0.out_ready = ordy;
        for (int i = 0; i < N; i++) if0.req_data[i*WIDTH +: WIDTH] = data[i];
        #1;
    endtask

    // Reference model: state after each edge.
    bit          m_valid = 0;
    int          m_data  = 0;
    int          m_src   = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    int          m_cnt4  = 0;

    always @(negedge clk) begin
        int  win;
        bit  can;
        logic [N-1:0] exp_rr;
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && if0.req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        can    = !m_valid || if0.out_ready;
        exp_rr = (!rst && can && win >= 0) ? N'(1 << win) : '0;

        chk("m_req_ready", if0.req_ready, exp_rr);
        chk("m_req_ready_c4", if1.req_ready, exp_rr);
        chk("m_out_valid", if0.out_valid, m_valid);
        chk("m_pkt_count", if0.pkt_count, m_cnt);
        chk("m_pkt_count_c4", if1.pkt_count, m_cnt4);
        if (m_valid) begin
            chk("m_out_data", if0.out_data, m_data);
            chk("m_out_src", if0.out_src, m_src);
        end

        if (rst) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (m_valid && if0.out_ready) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
                m_valid = 0;
            end
            if (exp_rr != 0) begin
                m_valid = 1;
                m_data  = int'(if0.req_data[win*WIDTH +: WIDTH]);
                m_src   = win;
                m_ptr   = (win + 1) % N;
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) data[i] = WIDTH'(11'h0F0 + i);
        if0.req_valid = '1;
        if0.out_ready = 1'b1;
        for (int i = 0; i < N; i++) if0.req_data[i*WIDTH +: WIDTH] = data[i];

        // Reset held two cycles with everything requesting
        repeat (2) begin
            drive(1, 5'b11111, 1);
            chk("rst_req_ready", if0.req_ready, 0);
            chk("rst_out_valid", if0.out_valid, 0);
            chk("rst_pkt_count", if0.pkt_count, 0);
        end

        // Fairness: 0,1,2,3,4,0,1 with no bubble
        for (int k = 0; k < 7; k++) begin
            drive(0, 5'b11111, 1);
            chk("fair_grant", if0.req_ready, 32'(1 << (k % 5)));
            if (k > 0) begin
                chk("fair_no_bubble", if0.out_valid, 1);
                chk("fair_src", if0.out_src, (k - 1) % 5);
            end
        end
        drive(0, 5'b00000, 1);
        chk("drain_src", if0.out_src, 1);
        drive(0, 5'b00000, 1);
        chk("drain_empty", if0.out_valid, 0);
        chk("drain_count", if0.pkt_count, 7);

        // Single requester
        data[2] = 11'h0F2;
        drive(0, 5'b00100, 1);
        chk("single_grant", if0.req_ready, 5'b00100);
        drive(0, 5'b00000, 1);
        chk("single_valid", if0.out_valid, 1);
        chk("single_data", if0.out_data, 11'h0F2);
        chk("single_src", if0.out_src, 2);
        chk("single_cnt_before", if0.pkt_count, 7);
        drive(0, 5'b00000, 0);
        chk("single_cnt_after", if0.pkt_count, 8);

        // Backpressure: hold 11'h1A2 for 5 cycles
        data[3] = 11'h1A2;
        drive(0, 5'b01000, 0);
        chk("bp_load_grant", if0.req_ready, 5'b01000);
        repeat (5) begin
            drive(0, 5'b01010, 0);
            chk("bp_hold_data", if0.out_data, 11'h1A2);
            chk("bp_no_grant", if0.req_ready, 0);
        end
        drive(0, 5'b01010, 1);
        chk("bp_release_grant", if0.req_ready, 5'b00010);
        drive(0, 5'b01000, 1);
        chk("bp_refill_src", if0.out_src, 1);
        chk("bp_refill_data", if0.out_data, 11'h0F1);
        chk("bp_next_grant", if0.req_ready, 5'b01000);

        // Wrap-around
        drive(0, 5'b10000, 1);
        chk("wrap_g4", if0.req_ready, 5'b10000);
        drive(0, 5'b01001, 1);
        chk("wrap_g0", if0.req_ready, 5'b00001);
        drive(0, 5'b01000, 1);
        chk("wrap_g3", if0.req_ready, 5'b01000);
        drive(0, 5'b10001, 1);
        chk("wrap_4_first", if0.req_ready, 5'b10000);
        drive(0, 5'b00001, 1);
        chk("wrap_0_after", if0.req_ready, 5'b00001);
        drive(0, 5'b00000, 1);
        drive(0, 5'b00000, 1);

        // Saturation of the 4-bit counter
        repeat (20) drive(0, 5'b11111, 1);
        drive(0, 5'b00000, 1);
        drive(0, 5'b00000, 1);
        chk("sat_cnt4", if1.pkt_count, 15);

        // Reset mid-operation drops the held packet
        drive(0, 5'b11111, 0);
        drive(1, 5'b11111, 1);
        chk("midrst_no_grant", if0.req_ready, 0);
        drive(0, 5'b00000, 1);
        chk("midrst_empty", if0.out_valid, 0);
        chk("midrst_cnt", if0.pkt_count, 0);
        chk("midrst_cnt4", if1.pkt_count, 0);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

Synchronous round-robin arbiter and output register that shares one 11-bit node output link among N requesters (four neighbour input ports plus local injection). Sits between a node's input buffers/injection path and one output port. Grants at most one packet per cycle with a starvation-free rotating priority. Holds the granted packet in a one-entry output register until the downstream link accepts it.

## Interface
- WIDTH, 11, packet width in bits; packets are opaque to this block.
- N, 5, number of requesters (0..3 = in1..in4, 4 = local generator).
- CNT_W, 16, width of the forwarded-packet counter.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  N  requester i has a packet on its data slice.
- req_data  input  N*WIDTH  packet of requester i at bits [i*WIDTH +: WIDTH].
- req_ready  output  N  grant; one-hot or all-zero.
- out_valid  output  1  output register holds a packet.
- out_data  output  WIDTH  held packet.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_src  output  $clog2(N)  index of requester whose packet is held.
- pkt_count  output  CNT_W  packets forwarded downstream, saturating.

## Operation
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = EMPTY, or FULL with out_ready=1 (drain and refill in the same cycle).
- Priority pointer ptr (0..N-1). When can_accept, the winner is the first i with req_valid[i]=1 scanning ptr, ptr+1, ..., wrapping N-1 to 0.
- req_ready[winner]=1 combinationally in that cycle. All other bits are 0. All bits are 0 when can_accept=0, when no request is valid, or while rst=1.
- Transfer occurs on req_valid[i] and req_ready[i]. On the next edge:
  - out_data <= slice i;
  - out_src <= i;
  - out_valid <= 1;
  - ptr <= (i+1) mod N.
- The pointer changes only on a transfer.
- Requesters hold valid and data stable until granted; retraction is illegal.
- Output handshake occurs on out_valid and out_ready. Without a simultaneous transfer, the next state is EMPTY and out_valid <= 0.
- out_data and out_src hold their value while FULL and out_ready=0.
- pkt_count increments by 1 per output handshake and saturates at 2^CNT_W-1 (no wrap).
- Transitions:
  - EMPTY stays EMPTY when no request is valid.
  - EMPTY goes to FULL on a transfer.
  - FULL stays FULL when out_ready=0.
  - FULL with out_ready=1 and a transfer stays FULL and loads the new packet.
  - FULL with out_ready=1 and no valid request goes to EMPTY.
- N=1: the pointer is constant 0 and grant = req_valid & can_accept.

## Timing
- Reset values (registered, applied on the edge where rst=1):
  - out_valid=0, out_data=0, out_src=0, ptr=0, pkt_count=0.
  - req_ready=0 combinationally while rst=1.
- Reset mid-operation discards any held packet with no downstream handshake. A requester granted in the reset cycle is not considered transferred.
- Latency: a packet transferred at edge k is on out_data/out_valid after edge k, i.e. visible in cycle k+1.
- Throughput: one packet per cycle when out_ready is held at 1.
- Combinational paths:
  - req_valid to req_ready;
  - out_ready to req_ready.
- There is no path from req_data to any output in the same cycle.

## Test plan
- Reset: hold rst=1 for 2 cycles with req_valid=5'b11111 and out_ready=1 -> req_ready=0, out_valid=0, pkt_count=0 throughout. After release, the first grant goes to requester 0.
- Single requester: req_valid[2]=1, slice 2=11'h0F2, out_ready=1 -> req_ready=5'b00100 that cycle. Next cycle out_valid=1, out_data=11'h0F2, out_src=2. pkt_count=1 after the following edge.
- Fairness: all 5 valid continuously with distinct data, out_ready=1 -> grants 0,1,2,3,4,0,1 on consecutive cycles, with no bubble on out_valid.
- Backpressure: FULL with out_data=11'h1A2, out_ready=0 for 5 cycles, requesters 1 and 3 valid -> out_data stays 11'h1A2 and req_ready=0 for all 5 cycles. On the cycle out_ready rises, the next pointer-order requester is granted and loaded the same edge.
- Wrap-around: last grant was 4 (ptr=0), then requesters 0 and 3 valid -> 0 granted, then 3. With last grant 3, requesters 0 and 4 valid -> 4 granted before 0.
- Saturation: CNT_W=4, 20 back-to-back packets -> pkt_count reaches 15 and stays 15.
